// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN ("elevator algorithm") controller for one car.
// The car keeps moving in its scan direction while requests lie ahead, and
// reverses only when none remain. Unknown position after reset is resolved by
// homing downwards. The emergency input parks the car at the next floor with
// the door open.
// Optional feature macro: ELEV_OBST_EN. When defined, door_obst keeps the door
// open (reloads the dwell in DOOR, blocks the exit from EMG_HOLD). When it is
// not defined, door_obst is ignored.
module elevator_scan_ctrl #(
    parameter int FLOORS     = 8,
    parameter int DOOR_TICKS = 50
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLOORS-1:0]            car_req,
    input  logic [FLOORS-1:0]            hall_up,
    input  logic [FLOORS-1:0]            hall_dn,
    input  logic [FLOORS-1:0]            sensors,
    input  logic                         emg,
    input  logic                         door_obst,
    output logic [1:0]                   motor,
    output logic [$clog2(FLOORS+1)-1:0]  disp,
    output logic                         door_open,
    output logic                         dir_up,
    output logic [3*FLOORS-1:0]          pend
);

    localparam int DW = $clog2(FLOORS + 1);
    localparam int IW = $clog2(FLOORS);
    localparam int CW = $clog2(DOOR_TICKS);
    localparam logic [IW-1:0]     TOP       = IW'(FLOORS - 1);
    localparam logic [FLOORS-1:0] ONE       = FLOORS'(1);
    localparam logic [FLOORS-1:0] UP_MASK   = ~(ONE << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_MASK   = ~ONE;
    localparam logic [CW-1:0]     DWELL_MAX = CW'(DOOR_TICKS - 1);
    localparam logic [1:0]        M_STOP    = 2'b00;
    localparam logic [1:0]        M_UP      = 2'b01;
    localparam logic [1:0]        M_DN      = 2'b10;

    typedef enum logic [2:0] {IDLE, UP, DOWN, DOOR, EMG_MOVE, EMG_HOLD} state_t;

    state_t            state;
    logic [FLOORS-1:0] pend_car, pend_up, pend_dn;
    logic [FLOORS-1:0] car_q, up_q, dn_q;
    logic [CW-1:0]     dwell;

    logic              sens_ok;
    logic [IW-1:0]     sens_idx;
    logic              known;
    logic [IW-1:0]     cur_idx;
    logic [IW-1:0]     f;
    logic [FLOORS-1:0] f_bit, all_req, above_mask, below_mask;
    logic              req_above, req_below, req_here;
    logic              stop_up, stop_dn, serve_up, reverse, enter_door;
    logic [FLOORS-1:0] rise_car, rise_up, rise_dn, door_mask;
    logic [FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic              press_here, obst, reload;
    logic [1:0]        emg_motor;

    assign pend    = {pend_dn, pend_up, pend_car};
    assign known   = (disp != '0);
    assign cur_idx = IW'(disp - DW'(1));

`ifdef ELEV_OBST_EN
    assign obst = door_obst;
`else
    logic unused_obst;
    assign obst        = 1'b0;
    assign unused_obst = door_obst;
`endif

    // Sensor decode: only a strictly one-hot vector names a floor.
    always_comb begin
        sens_ok  = (sensors != '0) && ((sensors & (sensors - ONE)) == '0);
        sens_idx = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (sensors[i]) sens_idx = IW'(i);
        end
    end

    // Scan decisions at the floor of interest (live sensor while moving, else last known floor).
    always_comb begin
        f          = (state == UP || state == DOWN) ? sens_idx : cur_idx;
        f_bit      = ONE << f;
        all_req    = pend_car | pend_up | pend_dn;
        above_mask = ~((f_bit << 1) - ONE);
        below_mask = f_bit - ONE;
        req_above  = |(all_req & above_mask);
        req_below  = |(all_req & below_mask);
        req_here   = |(all_req & f_bit);
        stop_up    = (|((pend_car | pend_up) & f_bit)) || ((|(pend_dn & f_bit)) && !req_above) || (f == TOP);
        stop_dn    = (|((pend_car | pend_dn) & f_bit)) || ((|(pend_up & f_bit)) && !req_below) || (f == '0);
        serve_up   = (state == UP);
        // An idle car serves everybody waiting at its floor, whatever their direction.
        reverse    = (state == IDLE) || (serve_up ? !req_above : !req_below);
        enter_door = 1'b0;
        if (!emg) begin
            case (state)
                IDLE:    enter_door = known && req_here;
                UP:      enter_door = sens_ok && stop_up;
                DOWN:    enter_door = sens_ok && stop_dn;
                default: enter_door = 1'b0;
            endcase
        end
        clr_car = enter_door ? f_bit : '0;
        clr_up  = (enter_door && (serve_up || reverse)) ? f_bit : '0;
        clr_dn  = (enter_door && (!serve_up || reverse)) ? f_bit : '0;
    end

    // Button edges, door-floor press suppression, dwell reload and emergency motor command.
    always_comb begin
        rise_car   = car_req & ~car_q;
        rise_up    = hall_up & ~up_q & UP_MASK;
        rise_dn    = hall_dn & ~dn_q & DN_MASK;
        door_mask  = (state == DOOR) ? (ONE << cur_idx) : '0;
        press_here = |((rise_car | rise_up | rise_dn) & door_mask);
        reload     = press_here || obst;
        if (dir_up) emg_motor = (known && cur_idx == TOP) ? M_STOP : M_UP;
        else        emg_motor = (known && cur_idx == '0)  ? M_STOP : M_DN;
    end

    // Previous button levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            car_q <= car_req;
            up_q  <= hall_up;
            dn_q  <= hall_dn;
        end
    end

    // Position tracking: invalid sensor vectors keep the last floor shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          disp <= '0;
        else if (sens_ok) disp <= DW'(sens_idx) + DW'(1);
    end

    // Main controller: pending requests, state, motor, door and scan direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            motor     <= M_STOP;
            door_open <= 1'b0;
            dir_up    <= 1'b1;
            pend_car  <= '0;
            pend_up   <= '0;
            pend_dn   <= '0;
            dwell     <= '0;
        end else begin
            pend_car <= (pend_car & ~clr_car) | (rise_car & ~door_mask);
            pend_up  <= (pend_up  & ~clr_up)  | (rise_up  & ~door_mask);
            pend_dn  <= (pend_dn  & ~clr_dn)  | (rise_dn  & ~door_mask);
            case (state)
                IDLE: begin
                    if (emg) begin
                        if (sens_ok) begin
                            state     <= EMG_HOLD;
                            door_open <= 1'b1;
                            motor     <= M_STOP;
                        end else begin
                            state <= EMG_MOVE;
                            motor <= emg_motor;
                        end
                    end else if (!known) begin
                        if (|all_req) begin
                            state  <= DOWN;
                            dir_up <= 1'b0;
                            motor  <= M_DN;
                        end
                    end else if (enter_door) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        dwell     <= DWELL_MAX;
                    end else if (dir_up ? req_above : req_below) begin
                        state <= dir_up ? UP : DOWN;
                        motor <= dir_up ? M_UP : M_DN;
                    end else if (dir_up ? req_below : req_above) begin
                        state  <= dir_up ? DOWN : UP;
                        motor  <= dir_up ? M_DN : M_UP;
                        dir_up <= !dir_up;
                    end
                end
                UP, DOWN: begin
                    if (emg) begin
                        state <= EMG_MOVE;
                        motor <= emg_motor;
                    end else if (enter_door) begin
                        state     <= DOOR;
                        motor     <= M_STOP;
                        door_open <= 1'b1;
                        dwell     <= DWELL_MAX;
                        if (reverse) dir_up <= !serve_up;
                    end
                end
                DOOR: begin
                    if (reload) begin
                        dwell <= DWELL_MAX;
                    end else if (dwell == '0) begin
                        state     <= emg ? EMG_HOLD : IDLE;
                        door_open <= emg;
                    end else begin
                        dwell <= dwell - CW'(1);
                    end
                end
                EMG_MOVE: begin
                    if (sens_ok) begin
                        state     <= EMG_HOLD;
                        motor     <= M_STOP;
                        door_open <= 1'b1;
                    end else begin
                        motor <= emg_motor;
                    end
                end
                EMG_HOLD: begin
                    if (!emg && !obst) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    motor <= M_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (FLOORS=8, DOOR_TICKS=50).
module tb_elevator_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  car_req, hall_up, hall_dn, sensors;
    logic        emg, door_obst;
    logic [1:0]  motor;
    logic [3:0]  disp;
    logic        door_open, dir_up;
    logic [23:0] pend;

    int checks = 0;
    int passed = 0;

    elevator_scan_ctrl #(.FLOORS(8), .DOOR_TICKS(50)) dut (
        .clk(clk), .rst(rst), .car_req(car_req), .hall_up(hall_up), .hall_dn(hall_dn),
        .sensors(sensors), .emg(emg), .door_obst(door_obst), .motor(motor), .disp(disp),
        .door_open(door_open), .dir_up(dir_up), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; car_req = '0; hall_up = '0; hall_dn = '0; sensors = '0; emg = 1'b0; door_obst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_sens(input logic [7:0] v, input int n);
        sensors = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] c, input logic [7:0] u, input logic [7:0] d);
        car_req = c; hall_up = u; hall_dn = d;
        @(negedge clk);
        car_req = '0; hall_up = '0; hall_dn = '0;
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int unsigned dummy;
        rst = 1'b1; car_req = '0; hall_up = '0; hall_dn = '0; sensors = '0; emg = 1'b0; door_obst = 1'b0;
        repeat (2) @(negedge clk);
        dummy = 0;
        checks++; if (motor !== 2'b00) $display("FAIL rst_motor: got %b expected 00", motor); else passed++;
        checks++; if (disp !== 4'd0) $display("FAIL rst_disp: got %0d expected 0", disp); else passed++;
        checks++; if (door_open !== 1'b0) $display("FAIL rst_door: got %b expected 0", door_open); else passed++;
        checks++; if (dir_up !== 1'b1) $display("FAIL rst_dir: got %b expected 1", dir_up); else passed++;
        checks++; if (pend !== 24'h0) $display("FAIL rst_pend: got %h expected 000000", pend); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_homing();
        int n;
        do_reset();
        press(8'h20, 8'h00, 8'h00);
        checks++; if (pend !== 24'h000020) $display("FAIL home_pend_set: got %h expected 000020", pend); else passed++;
        checks++; if (motor !== 2'b00) $display("FAIL home_motor_wait: got %b expected 00", motor); else passed++;
        @(negedge clk);
        checks++; if (motor !== 2'b10) $display("FAIL home_motor_down: got %b expected 10", motor); else passed++;
        checks++; if (dir_up !== 1'b0) $display("FAIL home_dir: got %b expected 0", dir_up); else passed++;
        set_sens(8'h00, 5);
        checks++; if (motor !== 2'b10 || disp !== 4'd0) $display("FAIL home_travel: got motor %b disp %0d expected 10/0", motor, disp); else passed++;
        set_sens(8'h01, 1);
        checks++; if (disp !== 4'd1) $display("FAIL home_disp1: got %0d expected 1", disp); else passed++;
        checks++; if (door_open !== 1'b1 || motor !== 2'b00) $display("FAIL home_bottom_stop: got door %b motor %b expected 1/00", door_open, motor); else passed++;
        count_door(n);
        checks++; if (n != 50) $display("FAIL home_dwell1: got %0d expected 50", n); else passed++;
        @(negedge clk);
        checks++; if (motor !== 2'b01) $display("FAIL home_motor_up: got %b expected 01", motor); else passed++;
        set_sens(8'h00, 2);
        set_sens(8'h02, 2);
        checks++; if (disp !== 4'd2 || motor !== 2'b01) $display("FAIL pass_floor2: got disp %0d motor %b expected 2/01", disp, motor); else passed++;
        set_sens(8'h03, 3);
        checks++; if (disp !== 4'd2 || motor !== 2'b01) $display("FAIL bad_sensor: got disp %0d motor %b expected 2/01", disp, motor); else passed++;
        set_sens(8'h00, 2); set_sens(8'h04, 2); set_sens(8'h00, 2); set_sens(8'h08, 2);
        set_sens(8'h00, 2); set_sens(8'h10, 2); set_sens(8'h00, 2);
        checks++; if (motor !== 2'b01) $display("FAIL home_still_up: got %b expected 01", motor); else passed++;
        set_sens(8'h20, 1);
        checks++; if (disp !== 4'd6 || door_open !== 1'b1 || motor !== 2'b00) $display("FAIL stop_floor6: got disp %0d door %b motor %b expected 6/1/00", disp, door_open, motor); else passed++;
        checks++; if (pend !== 24'h0) $display("FAIL clear_car5: got %h expected 000000", pend); else passed++;
        checks++; if (dir_up !== 1'b0) $display("FAIL reverse_dir6: got %b expected 0", dir_up); else passed++;
        count_door(n);
        checks++; if (n != 50) $display("FAIL home_dwell6: got %0d expected 50", n); else passed++;
    endtask

    task automatic test_scan_reverse();
        int n;
        do_reset();
        set_sens(8'h02, 1);
        checks++; if (disp !== 4'd2 || motor !== 2'b00) $display("FAIL scan_start: got disp %0d motor %b expected 2/00", disp, motor); else passed++;
        press(8'h40, 8'h00, 8'h10);
        checks++; if (pend !== 24'h100040) $display("FAIL scan_pend: got %h expected 100040", pend); else passed++;
        @(negedge clk);
        checks++; if (motor !== 2'b01) $display("FAIL scan_go_up: got %b expected 01", motor); else passed++;
        set_sens(8'h00, 2); set_sens(8'h04, 2); set_sens(8'h00, 2); set_sens(8'h08, 2); set_sens(8'h00, 2);
        set_sens(8'h10, 2);
        checks++; if (motor !== 2'b01 || disp !== 4'd5) $display("FAIL scan_pass5: got motor %b disp %0d expected 01/5", motor, disp); else passed++;
        set_sens(8'h00, 2); set_sens(8'h20, 2); set_sens(8'h00, 2);
        set_sens(8'h40, 1);
        checks++; if (door_open !== 1'b1 || disp !== 4'd7 || motor !== 2'b00) $display("FAIL scan_stop7: got door %b disp %0d motor %b expected 1/7/00", door_open, disp, motor); else passed++;
        checks++; if (pend !== 24'h100000) $display("FAIL scan_pend7: got %h expected 100000", pend); else passed++;
        checks++; if (dir_up !== 1'b0) $display("FAIL scan_dir7: got %b expected 0", dir_up); else passed++;
        count_door(n);
        checks++; if (n != 50) $display("FAIL scan_dwell7: got %0d expected 50", n); else passed++;
        @(negedge clk);
        checks++; if (motor !== 2'b10) $display("FAIL scan_go_down: got %b expected 10", motor); else passed++;
        set_sens(8'h00, 2); set_sens(8'h20, 2);
        checks++; if (motor !== 2'b10) $display("FAIL scan_pass6: got %b expected 10", motor); else passed++;
        set_sens(8'h00, 2);
        set_sens(8'h10, 1);
        checks++; if (door_open !== 1'b1 || disp !== 4'd5) $display("FAIL scan_stop5: got door %b disp %0d expected 1/5", door_open, disp); else passed++;
        checks++; if (pend !== 24'h0) $display("FAIL scan_clear_dn4: got %h expected 000000", pend); else passed++;
        count_door(n);
    endtask

    task automatic test_door_reload();
        int n;
        do_reset();
        set_sens(8'h04, 1);
        press(8'h04, 8'h00, 8'h00);
        @(negedge clk);
        checks++; if (door_open !== 1'b1) $display("FAIL reload_open: got %b expected 1", door_open); else passed++;
        n = 0;
        while (door_open === 1'b1 && n < 400) begin
            n++;
            if (n == 30) car_req = 8'h04;
            else if (n == 31) begin
                car_req = 8'h00;
                checks++; if (pend !== 24'h0) $display("FAIL reload_no_pend: got %h expected 000000", pend); else passed++;
            end
            @(negedge clk);
        end
        checks++; if (n != 80) $display("FAIL reload_dwell: got %0d expected 80", n); else passed++;
        checks++; if (pend !== 24'h0) $display("FAIL reload_pend_end: got %h expected 000000", pend); else passed++;
    endtask

    task automatic test_emg();
        do_reset();
        set_sens(8'h04, 1);
        press(8'h40, 8'h00, 8'h00);
        @(negedge clk);
        checks++; if (motor !== 2'b01) $display("FAIL emg_pre_up: got %b expected 01", motor); else passed++;
        set_sens(8'h00, 2);
        emg = 1'b1;
        set_sens(8'h00, 1);
        checks++; if (motor !== 2'b01) $display("FAIL emg_move: got %b expected 01", motor); else passed++;
        set_sens(8'h00, 3);
        checks++; if (motor !== 2'b01 || door_open !== 1'b0) $display("FAIL emg_move2: got motor %b door %b expected 01/0", motor, door_open); else passed++;
        set_sens(8'h08, 1);
        checks++; if (door_open !== 1'b1 || motor !== 2'b00 || disp !== 4'd4) $display("FAIL emg_hold: got door %b motor %b disp %0d expected 1/00/4", door_open, motor, disp); else passed++;
        repeat (10) @(negedge clk);
        checks++; if (door_open !== 1'b1 || motor !== 2'b00) $display("FAIL emg_hold_long: got door %b motor %b expected 1/00", door_open, motor); else passed++;
        checks++; if (pend !== 24'h000040) $display("FAIL emg_pend_kept: got %h expected 000040", pend); else passed++;
        emg = 1'b0;
        @(negedge clk);
        checks++; if (door_open !== 1'b0 || pend !== 24'h000040) $display("FAIL emg_release: got door %b pend %h expected 0/000040", door_open, pend); else passed++;
        @(negedge clk);
        checks++; if (motor !== 2'b01) $display("FAIL emg_resume: got %b expected 01", motor); else passed++;
        do_reset();
        set_sens(8'h01, 1);
        emg = 1'b1;
        @(negedge clk);
        checks++; if (door_open !== 1'b1 || motor !== 2'b00) $display("FAIL emg_idle_hold: got door %b motor %b expected 1/00", door_open, motor); else passed++;
        emg = 1'b0;
        @(negedge clk);
        checks++; if (door_open !== 1'b0) $display("FAIL emg_idle_release: got %b expected 0", door_open); else passed++;
    endtask

    task automatic test_obst();
        int n;
        int exp_n;
`ifdef ELEV_OBST_EN
        exp_n = 150;
`else
        exp_n = 50;
`endif
        do_reset();
        set_sens(8'h01, 1);
        press(8'h01, 8'h00, 8'h00);
        @(negedge clk);
        n = 0;
        while (door_open === 1'b1 && n < 400) begin
            n++;
            door_obst = (n <= 100);
            @(negedge clk);
        end
        door_obst = 1'b0;
        checks++; if (n != exp_n) $display("FAIL obst_dwell: got %0d expected %0d", n, exp_n); else passed++;
    endtask

    task automatic test_ignored_bits();
        do_reset();
        press(8'h00, 8'h80, 8'h01);
        checks++; if (pend !== 24'h0) $display("FAIL ignored_bits_pend: got %h expected 000000", pend); else passed++;
        @(negedge clk);
        checks++; if (motor !== 2'b00) $display("FAIL ignored_bits_motor: got %b expected 00", motor); else passed++;
    endtask

    task automatic test_reset_midtravel();
        do_reset();
        set_sens(8'h08, 1);
        press(8'h80, 8'h00, 8'h00);
        @(negedge clk);
        set_sens(8'h00, 2);
        checks++; if (motor !== 2'b01 || disp !== 4'd4) $display("FAIL mid_pre: got motor %b disp %0d expected 01/4", motor, disp); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (disp !== 4'd0 || motor !== 2'b00 || pend !== 24'h0) $display("FAIL mid_async_rst: got disp %0d motor %b pend %h expected 0/00/0", disp, motor, pend); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (disp !== 4'd0 || motor !== 2'b00) $display("FAIL mid_unknown: got disp %0d motor %b expected 0/00", disp, motor); else passed++;
        set_sens(8'h10, 1);
        checks++; if (disp !== 4'd5) $display("FAIL mid_relearn: got %0d expected 5", disp); else passed++;
    endtask

    initial begin
        test_reset();
        test_homing();
        test_scan_reverse();
        test_door_reload();
        test_emg();
        test_obst();
        test_ignored_bits();
        test_reset_midtravel();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 SHALL have parameter FLOORS, default 8, number of served floors, legal 2..15.
REQ-002 SHALL have parameter DOOR_TICKS, default 50, door-open dwell in clk cycles, legal >=2.
REQ-003 SHALL derive local DW = $clog2(FLOORS+1), the width of the display.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port car_req, input, FLOORS, cabin buttons, bit i = floor i+1.
REQ-007 SHALL have port hall_up, input, FLOORS, hall Up buttons, with bit FLOORS-1 ignored.
REQ-008 SHALL have port hall_dn, input, FLOORS, hall Down buttons, with bit 0 ignored.
REQ-009 SHALL have port sensors, input, FLOORS, floor-level sensors, one-hot, all-zero between floors.
REQ-010 SHALL have port emg, input, 1, emergency request, level.
REQ-011 SHALL have port door_obst, input, 1, door obstruction, level.
REQ-012 SHALL have port motor, output, 2, with encodings 00 stop, 01 up, 10 down.
REQ-013 SHALL have port disp, output, DW, 1-based floor number, 0 = unknown.
REQ-014 SHALL have port door_open, output, 1, door command.
REQ-015 SHALL have port dir_up, output, 1, current scan direction.
REQ-016 SHALL have port pend, output, 3*FLOORS, packed {pend_dn, pend_up, pend_car}.

Function
REQ-017 SHALL register all outputs and drive them from state registers only.
REQ-018 SHALL register a request one cycle after the rising edge of its button bit, setting the matching pending bit.
REQ-019 SHALL treat a sensor vector that is not one-hot as no floor, holding the last valid index and disp.
REQ-020 SHALL implement states IDLE, UP, DOWN, DOOR, EMG_MOVE and EMG_HOLD.
REQ-021 IDLE SHALL start DOWN if no floor is known and any request is pending (homing).
REQ-022 IDLE with a known floor SHALL:
- choose DOOR if a request is at the current floor;
- else continue in dir_up if requests lie ahead;
- else reverse;
- else remain in IDLE.
REQ-023 UP at floor i SHALL stop (enter DOOR) on any of:
- pend_car[i] or pend_up[i];
- pend_dn[i] with no pending request above i;
- top floor reached.
REQ-024 DOWN SHALL follow the mirror of REQ-023, using pend_dn and pend_car, with the bottom floor as the forced stop.
REQ-025 On DOOR entry, SHALL clear pend_car[i] and the pending hall bit of the served direction at floor i, clearing both when reversing.
REQ-026 DOOR SHALL assert door_open for DOOR_TICKS cycles, then enter IDLE.
REQ-027 A new press at the current floor during DOOR SHALL reload the dwell counter and SHALL NOT set a pending bit.
REQ-028 A press and a clear of the same bit in the same cycle SHALL resolve to clear only if the door is open at that floor.
REQ-029 emg in UP, DOWN or IDLE-between-floors SHALL enter EMG_MOVE, moving in dir_up to the next valid sensor, with the motor forced to 00 at top or bottom.
REQ-030 Reaching the next valid sensor in EMG_MOVE SHALL enter EMG_HOLD.
REQ-031 emg in IDLE at a floor, or at DOOR expiry, SHALL enter EMG_HOLD.
REQ-032 EMG_HOLD SHALL hold door_open=1 and motor=00, keep all pending bits, and enter IDLE when emg deasserts.
REQ-033 The motor SHALL be 00 in every state except UP, DOWN and EMG_MOVE.

Reset
REQ-034 rst SHALL force state IDLE, motor=00, disp=0, door_open=0, dir_up=1, pend=0, the dwell counter to 0 and the edge-detect registers to 0.
REQ-035 Reset mid-travel SHALL leave the floor unknown until the next valid sensor.

Configuration
REQ-036 With ELEV_OBST_EN defined, door_obst=1 in DOOR SHALL reload the dwell counter every cycle, and door_obst=1 in EMG_HOLD SHALL block exit.
REQ-037 Without ELEV_OBST_EN, door_obst SHALL be ignored.

Verification
REQ-038 Reset, sensors=0, car_req[5] pulse -> motor=10 until sensor[0]; then disp=1, UP to sensor[5], disp=6, door_open for 50 cycles.
REQ-039 Car at floor 2 moving up, hall_dn[4] and car_req[6] pending -> stops at floor 7 first, then reverses to floor 5; pend_dn[4] cleared at floor 5.
REQ-040 Door open at floor 3, car_req[2] pressed at cycle 30 -> door_open lasts 30+50 cycles total, pend_car[2] stays 0.
REQ-041 emg asserted mid-travel up between floors 3 and 4 -> motor=01 until sensor[3], then door_open=1 and motor=00 while emg=1; IDLE after release, pend unchanged.
REQ-042 With ELEV_OBST_EN, door_obst held 100 cycles in DOOR -> door_open stays 1 through the hold plus 50 cycles; without the macro -> closes after 50 cycles.
REQ-043 sensors=0b0011 while moving -> disp unchanged, no stop.
